// File: rtl/instr_decode.sv
// RV32I subset decoder with a one-deep valid/ready output register and flush.
// Optional DECODE_ILLEGAL_TRAP_EN enables the illegal flag and its saturating counter.
module instr_decode (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  instr_type,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] imm,
  output logic [2:0]  funct3,
  output logic        shamt_used,
  output logic        inc_pc,
  output logic        sub_sra,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        branch,
  output logic        illegal,
  output logic [3:0]  illegal_cnt
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned TYPE_W = 4;
  localparam int unsigned CNT_W  = 4;

  localparam logic [TYPE_W-1:0] T_R = TYPE_W'(0);
  localparam logic [TYPE_W-1:0] T_I = TYPE_W'(1);
  localparam logic [TYPE_W-1:0] T_S = TYPE_W'(2);
  localparam logic [TYPE_W-1:0] T_B = TYPE_W'(3);
  localparam logic [TYPE_W-1:0] T_U = TYPE_W'(4);
  localparam logic [TYPE_W-1:0] T_J = TYPE_W'(5);
  localparam logic [TYPE_W-1:0] T_N = TYPE_W'(7);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_sh = {27'b0, instr[24:20]};

  logic [TYPE_W-1:0] type_d;
  logic [XLEN-1:0]   imm_d;
  logic shamt_d, inc_pc_d, sub_sra_d, reg_write_d, mem_read_d, mem_write_d, branch_d;

  // Combinational decode of the incoming word; unknown opcode/funct3 falls through to type N.
  always_comb begin
    type_d      = T_N;
    imm_d       = '0;
    shamt_d     = 1'b0;
    inc_pc_d    = 1'b0;
    sub_sra_d   = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    branch_d    = 1'b0;
    case (opcode)
      OPC_OP: begin
        if (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101) begin
          type_d    = T_R;
          sub_sra_d = instr[30];
        end
      end
      OPC_OP_IMM: begin
        if (f3 == 3'b000) begin
          type_d = T_I;
          imm_d  = imm_i;
        end else if (f3 == 3'b001 || f3 == 3'b101) begin
          type_d    = T_R;
          imm_d     = imm_sh;
          shamt_d   = 1'b1;
          sub_sra_d = instr[30];
        end
      end
      OPC_LOAD: begin
        if (f3 == 3'b010) begin
          type_d     = T_I;
          imm_d      = imm_i;
          mem_read_d = 1'b1;
        end
      end
      OPC_JALR: begin
        if (f3 == 3'b000) begin
          type_d   = T_I;
          imm_d    = imm_i;
          inc_pc_d = 1'b1;
        end
      end
      OPC_STORE: begin
        if (f3 == 3'b010) begin
          type_d      = T_S;
          imm_d       = imm_s;
          mem_write_d = 1'b1;
        end
      end
      OPC_BRANCH: begin
        if (f3 == 3'b000 || f3 == 3'b001) begin
          type_d   = T_B;
          imm_d    = imm_b;
          branch_d = 1'b1;
        end
      end
      OPC_LUI: begin
        type_d = T_U;
        imm_d  = imm_u;
      end
      OPC_AUIPC: begin
        type_d   = T_U;
        imm_d    = imm_u;
        inc_pc_d = 1'b1;
      end
      OPC_JAL: begin
        type_d = T_J;
        imm_d  = imm_j;
      end
      default: ;
    endcase
    reg_write_d = (type_d == T_R || type_d == T_I || type_d == T_U || type_d == T_J) &&
                  (instr[11:7] != 5'd0);
  end

  logic accept;
  logic out_valid_q, out_valid_d;

  // Flush overrides both acceptance and downstream consumption.
  assign in_ready = !flush && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    if (flush)          out_valid_d = 1'b0;
    else if (accept)    out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;
  end

  logic [TYPE_W-1:0] type_q;
  logic [4:0]        rs1_q, rs2_q, rd_q;
  logic [XLEN-1:0]   imm_q;
  logic [2:0]        f3_q;
  logic shamt_q, inc_pc_q, sub_sra_q, reg_write_q, mem_read_q, mem_write_q, branch_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      type_q      <= T_N;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      imm_q       <= '0;
      f3_q        <= '0;
      shamt_q     <= 1'b0;
      inc_pc_q    <= 1'b0;
      sub_sra_q   <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      branch_q    <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      if (accept) begin
        type_q      <= type_d;
        rs1_q       <= instr[19:15];
        rs2_q       <= instr[24:20];
        rd_q        <= instr[11:7];
        imm_q       <= imm_d;
        f3_q        <= f3;
        shamt_q     <= shamt_d;
        inc_pc_q    <= inc_pc_d;
        sub_sra_q   <= sub_sra_d;
        reg_write_q <= reg_write_d;
        mem_read_q  <= mem_read_d;
        mem_write_q <= mem_write_d;
        branch_q    <= branch_d;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign instr_type = type_q;
  assign rs1        = rs1_q;
  assign rs2        = rs2_q;
  assign rd         = rd_q;
  assign imm        = imm_q;
  assign funct3     = f3_q;
  assign shamt_used = shamt_q;
  assign inc_pc     = inc_pc_q;
  assign sub_sra    = sub_sra_q;
  assign reg_write  = reg_write_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign branch     = branch_q;

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic             illegal_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_d;

  assign illegal_d = (type_d == T_N);

  always_comb begin
    cnt_d = cnt_q;
    if (accept && illegal_d && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (accept) illegal_q <= illegal_d;
    end
  end

  assign illegal     = illegal_q;
  assign illegal_cnt = cnt_q;
`else
  assign illegal     = 1'b0;
  assign illegal_cnt = '0;
`endif

endmodule
